// File: rtl/adder_operand_sequencer_if.sv
// Handshake and operand bus between the operand sequencer, its byte source,
// the adder stage and the result consumer.
interface adder_operand_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] sum_in;
   logic [DATA_W-1:0] res_data;
   logic              res_carry;
   logic              res_err;
   logic              res_valid;
   logic              res_ready;
   logic [CNT_W-1:0]  pair_count;
   logic              busy;

   modport master (
      input  in_data, in_valid, sum_in, res_ready,
      output in_ready, op_a, op_b, res_data, res_carry, res_err, res_valid,
             pair_count, busy
   );

   modport slave (
      output in_data, in_valid, sum_in, res_ready,
      input  in_ready, op_a, op_b, res_data, res_carry, res_err, res_valid,
             pair_count, busy
   );
endinterface

// File: rtl/adder_operand_sequencer.sv
// Pairs bytes into adder operands, holds them while the adder computes, then
// captures, checks and returns the adder's sum plus the carry it drops.
module adder_operand_sequencer #(
   parameter int DATA_W  = 8,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
)(
   input  logic                       clk,
   input  logic                       rst_n,
   adder_operand_sequencer_if.master  bus
);

   generate
      if (LATENCY < 1) begin : g_latency_check
         $error("adder_operand_sequencer: LATENCY must be >= 1");
      end
   endgenerate

   localparam int WC_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

   typedef enum logic [1:0] {LOAD_A, LOAD_B, WAIT, OUT} state_t;

   state_t            state;
   logic              a_pending;
   logic [WC_W-1:0]   wait_cnt;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] res_data;
   logic              res_carry;
   logic              res_err;
   logic              res_valid;
   logic [CNT_W-1:0]  pair_count;
   logic              in_ready;
   logic              in_xfer;
   logic              res_xfer;
   logic [DATA_W:0]   sum_full;

   always_comb begin
      in_ready = 1'b0;
      case (state)
         LOAD_A, LOAD_B: in_ready = 1'b1;
         OUT:            in_ready = !a_pending;
         default:        in_ready = 1'b0;
      endcase
   end

   assign in_xfer  = bus.in_valid & in_ready;
   assign res_xfer = res_valid & bus.res_ready;
   // Widened add recovers the carry the adder stage truncates.
   assign sum_full = {1'b0, op_a} + {1'b0, op_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LOAD_A;
         a_pending  <= 1'b0;
         wait_cnt   <= '0;
         op_a       <= '0;
         op_b       <= '0;
         res_data   <= '0;
         res_carry  <= 1'b0;
         res_err    <= 1'b0;
         res_valid  <= 1'b0;
         pair_count <= '0;
      end else begin
         case (state)
            LOAD_A: if (in_xfer) begin
               op_a  <= bus.in_data;
               state <= LOAD_B;
            end
            LOAD_B: if (in_xfer) begin
               op_b     <= bus.in_data;
               wait_cnt <= WC_W'(LATENCY);
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  res_data  <= bus.sum_in;
                  res_carry <= sum_full[DATA_W];
                  res_err   <= (bus.sum_in != sum_full[DATA_W-1:0]);
                  res_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            OUT: begin
               // The next a may be taken early; the result stays untouched.
               if (in_xfer) begin
                  op_a      <= bus.in_data;
                  a_pending <= 1'b1;
               end
               if (res_xfer) begin
                  res_valid  <= 1'b0;
                  pair_count <= pair_count + 1'b1;
                  a_pending  <= 1'b0;
                  state      <= (a_pending || in_xfer) ? LOAD_B : LOAD_A;
               end
            end
            default: state <= LOAD_A;
         endcase
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.op_a       = op_a;
   assign bus.op_b       = op_b;
   assign bus.res_data   = res_data;
   assign bus.res_carry  = res_carry;
   assign bus.res_err    = res_err;
   assign bus.res_valid  = res_valid;
   assign bus.pair_count = pair_count;
   assign bus.busy       = (state != LOAD_A) || a_pending;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Scoreboard bench: two sequencers (LATENCY=1/CNT_W=16 and LATENCY=3/CNT_W=4)
// each paired with a behavioural registered adder.
module tb_adder_operand_sequencer;

   typedef struct packed {
      logic [7:0] d;
      logic       c;
      logic       e;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rst6_n = 1'b0;
   logic force_zero = 1'b0;

   int checks = 0;
   int errors = 0;
   int cnt1 = 0;
   int cnt6 = 0;
   res_t q1[$];
   res_t q6[$];
   res_t e1, e6;

   always #5 clk = ~clk;

   adder_operand_sequencer_if #(.DATA_W(8), .CNT_W(16)) b1 ();
   adder_operand_sequencer_if #(.DATA_W(8), .CNT_W(4))  b6 ();

   adder_operand_sequencer #(.DATA_W(8), .LATENCY(1), .CNT_W(16)) u_d1 (
      .clk(clk), .rst_n(rst_n), .bus(b1.master));
   adder_operand_sequencer #(.DATA_W(8), .LATENCY(3), .CNT_W(4)) u_d6 (
      .clk(clk), .rst_n(rst6_n), .bus(b6.master));

   // Registered adder stages; force_zero models a broken adder for d1.
   always @(posedge clk) b1.sum_in <= force_zero ? 8'h00 : b1.op_a + b1.op_b;
   always @(posedge clk) b6.sum_in <= b6.op_a + b6.op_b;

   function automatic res_t ref_model(input int a, input int b, input bit f);
      res_t r;
      int   s;
      s   = a + b;
      r.d = f ? 8'h00 : 8'(s % 256);
      r.c = (s > 255);
      r.e = f && ((s % 256) != 0);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tfail(input string name);
      checks++;
      errors++;
      $display("FAIL %s timed out", name);
   endtask

   always @(negedge clk) begin
      if (!rst_n) cnt1 = 0;
      else if (b1.res_valid && b1.res_ready) begin
         if (q1.size() == 0) tfail("d1_unexpected_result");
         else begin
            e1 = q1.pop_front();
            chk("d1_res_data",  32'(b1.res_data),  32'(e1.d));
            chk("d1_res_carry", 32'(b1.res_carry), 32'(e1.c));
            chk("d1_res_err",   32'(b1.res_err),   32'(e1.e));
            chk("d1_pair_count_before", 32'(b1.pair_count), 32'(cnt1 % 65536));
            cnt1++;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst6_n) cnt6 = 0;
      else if (b6.res_valid && b6.res_ready) begin
         if (q6.size() == 0) tfail("d6_unexpected_result");
         else begin
            e6 = q6.pop_front();
            chk("d6_res_data",  32'(b6.res_data),  32'(e6.d));
            chk("d6_res_carry", 32'(b6.res_carry), 32'(e6.c));
            chk("d6_res_err",   32'(b6.res_err),   32'(e6.e));
            chk("d6_pair_count_before", 32'(b6.pair_count), 32'(cnt6 % 16));
            cnt6++;
         end
      end
   end

   task automatic set_in(input int u, input logic v, input logic [7:0] d);
      if (u == 0) begin b1.in_valid = v; b1.in_data = d; end
      else        begin b6.in_valid = v; b6.in_data = d; end
   endtask

   task automatic set_rr(input int u, input logic r);
      if (u == 0) b1.res_ready = r;
      else        b6.res_ready = r;
   endtask

   function automatic logic get_rdy(input int u);
      return (u == 0) ? b1.in_ready : b6.in_ready;
   endfunction

   function automatic logic get_rv(input int u);
      return (u == 0) ? b1.res_valid : b6.res_valid;
   endfunction

   task automatic send_byte(input int u, input logic [7:0] d);
      int n;
      set_in(u, 1'b1, d);
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (get_rdy(u)) break;
      end
      if (n == 100) tfail("in_ready_wait");
      @(posedge clk); #1;
      set_in(u, 1'b0, 8'h00);
   endtask

   task automatic send_pair(input int u, input logic [7:0] a, input logic [7:0] b, input bit f);
      if (u == 0) q1.push_back(ref_model(int'(a), int'(b), f));
      else        q6.push_back(ref_model(int'(a), int'(b), f));
      send_byte(u, a);
      send_byte(u, b);
   endtask

   // Counts edges from the b transfer until res_valid is seen.
   task automatic wait_res(input int u, input int exp_lat);
      int n;
      for (n = 1; n <= 50; n++) begin
         @(posedge clk); #1;
         if (get_rv(u)) break;
      end
      if (n > 50) tfail("res_valid_wait");
      else chk("res_latency", 32'(n), 32'(exp_lat));
   endtask

   task automatic drain(input int u);
      logic r;
      int   n;
      for (n = 0; n < 200; n++) begin
         r = 1'($urandom_range(0, 1));
         set_rr(u, r);
         @(negedge clk);
         if (get_rv(u) && r) begin
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      if (n == 200) tfail("drain");
      set_rr(u, 1'b0);
   endtask

   initial begin
      int acc;
      logic [7:0] ra, rb;
      set_in(0, 1'b0, 8'h00);
      set_in(1, 1'b0, 8'h00);
      set_rr(0, 1'b0);
      set_rr(1, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst_in_ready",   32'(b1.in_ready),   32'd1);
      chk("rst_busy",       32'(b1.busy),       32'd0);
      chk("rst_res_valid",  32'(b1.res_valid),  32'd0);
      chk("rst_op_a",       32'(b1.op_a),       32'd0);
      chk("rst_pair_count", 32'(b1.pair_count), 32'd0);
      chk("rst6_in_ready",  32'(b6.in_ready),   32'd1);
      #1; rst_n = 1'b1; rst6_n = 1'b1;
      @(posedge clk); #1;

      // basic pair, latency 2 edges, count 1
      set_rr(0, 1'b1);
      send_pair(0, 8'h12, 8'h34, 1'b0);
      wait_res(0, 2);
      chk("t1_res_data", 32'(b1.res_data), 32'h46);
      @(posedge clk); #1;
      chk("t1_pair_count", 32'(b1.pair_count), 32'd1);
      chk("t1_res_valid_low", 32'(b1.res_valid), 32'd0);

      // carry out
      send_pair(0, 8'hFF, 8'h01, 1'b0);
      wait_res(0, 2);
      chk("t2_res_carry", 32'(b1.res_carry), 32'd1);
      @(posedge clk); #1;

      // broken adder
      force_zero = 1'b1;
      send_pair(0, 8'h12, 8'h34, 1'b1);
      wait_res(0, 2);
      chk("t4_res_err", 32'(b1.res_err), 32'd1);
      @(posedge clk); #1;
      force_zero = 1'b0;

      // backpressure in OUT with early a load
      set_rr(0, 1'b0);
      send_pair(0, 8'h33, 8'h44, 1'b0);
      wait_res(0, 2);
      set_in(0, 1'b1, 8'h10);
      acc = 0;
      repeat (5) begin
         @(negedge clk);
         if (b1.in_ready) acc++;
         @(posedge clk); #1;
      end
      set_in(0, 1'b0, 8'h00);
      chk("t3_accept_once", 32'(acc), 32'd1);
      chk("t3_in_ready_low", 32'(b1.in_ready), 32'd0);
      chk("t3_res_held", 32'(b1.res_data), 32'h77);
      chk("t3_op_a", 32'(b1.op_a), 32'h10);
      chk("t3_op_b_held", 32'(b1.op_b), 32'h44);
      q1.push_back(ref_model(32'h10, 32'h20, 1'b0));
      set_rr(0, 1'b1);
      @(posedge clk); #1;
      chk("t3_load_b_ready", 32'(b1.in_ready), 32'd1);
      chk("t3_load_b_busy", 32'(b1.busy), 32'd1);
      chk("t3_res_valid_low", 32'(b1.res_valid), 32'd0);
      send_byte(0, 8'h20);
      wait_res(0, 2);
      chk("t3_res_data", 32'(b1.res_data), 32'h30);
      @(posedge clk); #1;

      // random pairs with random result backpressure
      set_rr(0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         send_pair(0, ra, rb, 1'b0);
         wait_res(0, 2);
         drain(0);
      end

      // reset during WAIT
      set_rr(0, 1'b1);
      send_pair(0, 8'h55, 8'h66, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_res_valid", 32'(b1.res_valid),  32'd0);
      chk("t5_op_a",      32'(b1.op_a),       32'd0);
      chk("t5_op_b",      32'(b1.op_b),       32'd0);
      chk("t5_res_data",  32'(b1.res_data),   32'd0);
      chk("t5_pair_count",32'(b1.pair_count), 32'd0);
      chk("t5_busy",      32'(b1.busy),       32'd0);
      chk("t5_in_ready",  32'(b1.in_ready),   32'd1);
      q1.delete();
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      send_pair(0, 8'h01, 8'h02, 1'b0);
      wait_res(0, 2);
      chk("t5_res_after", 32'(b1.res_data), 32'h03);
      @(posedge clk); #1;
      chk("t5_count_after", 32'(b1.pair_count), 32'd1);

      // back-to-back on the LATENCY=3, CNT_W=4 instance
      set_rr(1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         send_pair(1, ra, rb, 1'b0);
         wait_res(1, 4);
      end
      @(posedge clk); #1;
      chk("t6_pair_count_wrap", 32'(b6.pair_count), 32'd0);
      chk("t6_res_valid_low", 32'(b6.res_valid), 32'd0);

      chk("q1_empty", 32'(q1.size()), 32'd0);
      chk("q6_empty", 32'(q6.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired before end of test");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
